// File: rtl/factorial_pkg.sv
// Shared types and constants for the factorial sequencer and its multiply stepper.
package factorial_pkg;

  localparam int W_OPR      = 64;
  localparam int W_RES      = 128;
  localparam int MUL_CYCLES = 64;
  localparam int CNT_W      = $clog2(MUL_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b01;

endpackage

// File: rtl/factorial_if.sv
// Level-signal bundle between the register block (master) and the factorial core (slave).
interface factorial_if #(
  parameter int W_OPR = factorial_pkg::W_OPR,
  parameter int W_RES = factorial_pkg::W_RES
);

  logic                   op_start;
  logic                   op_clear;
  logic                   intr_en;
  logic [W_OPR-1:0]       operand;
  logic [1:0]             op_done;
  logic [W_RES/2-1:0]     result_h;
  logic [W_RES/2-1:0]     result_l;
  logic                   irq;

  modport master (
    output op_start, op_clear, intr_en, operand,
    input  op_done, result_h, result_l, irq
  );

  modport slave (
    input  op_start, op_clear, intr_en, operand,
    output op_done, result_h, result_l, irq
  );

endinterface

// File: rtl/factorial_mul_step.sv
// Radix-2 shift-add multiplier: one multiplier bit per step, fixed MUL_CYCLES steps per product.
module factorial_mul_step #(
  parameter int W_OPR = factorial_pkg::W_OPR,
  parameter int W_RES = factorial_pkg::W_RES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             step,
  input  logic [W_RES-1:0] mcand_in,
  input  logic [W_OPR-1:0] mplr_in,
  output logic [W_RES-1:0] acc_next,
  output logic             last
);
  import factorial_pkg::*;

  logic [W_RES-1:0] acc;
  logic [W_RES-1:0] mcand;
  logic [W_OPR-1:0] mplr;
  logic [CNT_W-1:0] cnt;

  // acc_next is also the finished product when last is set, so the core can capture it on the final step
  always_comb begin
    if (mplr[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  assign last = (cnt == CNT_W'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= mcand_in;
      mplr  <= mplr_in;
      cnt   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CNT_W'(1);
    end else begin
      acc   <= acc;
      mcand <= mcand;
      mplr  <= mplr;
      cnt   <= cnt;
    end
  end

endmodule

// File: rtl/factorial_core.sv
// Factorial sequencer: computes operand! mod 2^W_RES by repeated shift-add multiplication.
module factorial_core #(
  parameter int W_OPR = factorial_pkg::W_OPR,
  parameter int W_RES = factorial_pkg::W_RES
) (
  input  logic        clk,
  input  logic        reset,
  factorial_if.slave  bus
);
  import factorial_pkg::*;

  state_t           state;
  state_t           state_next;
  logic             start_d;
  logic             start_edge;
  logic [W_RES-1:0] res;
  logic [W_OPR-1:0] n;
  logic [W_RES-1:0] result;
  logic             n_le_one;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [W_RES-1:0] acc_next;

  assign start_edge = bus.op_start & ~start_d;
  assign n_le_one   = (n <= W_OPR'(1));

  factorial_mul_step #(
    .W_OPR (W_OPR),
    .W_RES (W_RES)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.op_clear),
    .load     (mul_load),
    .step     (mul_step),
    .mcand_in (res),
    .mplr_in  (n),
    .acc_next (acc_next),
    .last     (mul_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (bus.op_clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = INIT;  else state_next = IDLE;
      INIT:    state_next = CHECK;
      CHECK:   if (n_le_one)   state_next = DONE;  else state_next = MUL;
      MUL:     if (mul_last)   state_next = CHECK; else state_next = MUL;
      DONE:    if (start_edge) state_next = INIT;  else state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Reset forces start_d low so a start held across reset is seen as a fresh edge; clear keeps sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d <= 1'b0;
      res     <= '0;
      n       <= '0;
      result  <= '0;
    end else if (bus.op_clear) begin
      start_d <= bus.op_start;
      res     <= '0;
      n       <= '0;
      result  <= '0;
    end else begin
      start_d <= bus.op_start;
      case (state)
        INIT: begin
          res <= W_RES'(1);
          n   <= bus.operand;
        end
        CHECK: begin
          if (n_le_one) begin
            result <= res;
          end
        end
        MUL: begin
          if (mul_last) begin
            res <= acc_next;
            n   <= n - W_OPR'(1);
          end
        end
        default: begin
          res <= res;
        end
      endcase
    end
  end

  always_comb begin
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    bus.op_done = ST_IDLE;
    case (state)
      IDLE:  bus.op_done = ST_IDLE;
      INIT:  bus.op_done = ST_BUSY;
      CHECK: begin
        bus.op_done = ST_BUSY;
        mul_load    = ~n_le_one;
      end
      MUL: begin
        bus.op_done = ST_BUSY;
        mul_step    = 1'b1;
      end
      DONE:    bus.op_done = ST_DONE;
      default: bus.op_done = ST_IDLE;
    endcase
  end

  assign bus.result_h = result[W_RES-1:W_OPR];
  assign bus.result_l = result[W_OPR-1:0];
  assign bus.irq      = bus.intr_en & (state == DONE);

endmodule
